// File: rtl/bridge_pkg.sv
// Shared encodings for the drawbridge controller: FSM states, road light codes
// and the output bundle decoded from a state.
package bridge_pkg;

    typedef enum logic [2:0] {
        ROAD_OPEN  = 3'd0,
        ROAD_WARN  = 3'd1,
        ROAD_DRAIN = 3'd2,
        RAISING    = 3'd3,
        BRIDGE_UP  = 3'd4,
        LOWERING   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } car_light_e;

    typedef struct packed {
        logic [1:0] car_light;
        logic       boat_light;
        logic       gate_down;
        logic       motor_up;
        logic       motor_down;
    } out_s;

    // Motors only ever run in states that also hold the gate down.
    function automatic out_s decode_outputs(input state_e s);
        out_s o;
        o = '0;
        o.car_light = GREEN;
        case (s)
            ROAD_OPEN:  o.car_light = GREEN;
            ROAD_WARN:  o.car_light = YELLOW;
            ROAD_DRAIN: begin
                o.car_light = RED;
                o.gate_down = 1'b1;
            end
            RAISING: begin
                o.car_light = RED;
                o.gate_down = 1'b1;
                o.motor_up  = 1'b1;
            end
            BRIDGE_UP: begin
                o.car_light  = RED;
                o.gate_down  = 1'b1;
                o.boat_light = 1'b1;
            end
            LOWERING: begin
                o.car_light  = RED;
                o.gate_down  = 1'b1;
                o.motor_down = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/bridge_timer.sv
// Loadable down-counter that saturates at zero; zero flag is the expiry
// indication used for exact N-cycle dwells (load N-1).
module bridge_timer
#(
    parameter int TW = 8
)
(
    input  logic          Clk,
    input  logic          Reset,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    output logic          o_zero
);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - TW'(1);
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/bridge_controller.sv
// Drawbridge sequencer: warn, block, drain, raise, hold, lower, reopen, with a
// sticky occupancy alarm and a min-green hold-off between boat cycles.
module bridge_controller
    import bridge_pkg::*;
#(
    parameter int GATE_CYCLES      = 8,
    parameter int MOVE_CYCLES      = 16,
    parameter int MAX_UP_CYCLES    = 64,
    parameter int MIN_GREEN_CYCLES = 32,
    parameter int TW               = 8
)
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       i_ExistCar,
    input  logic       i_BoatReq,
    input  logic       i_BoatClear,
    output logic [1:0] o_CarLight,
    output logic       o_BoatLight,
    output logic       o_GateDown,
    output logic       o_MotorUp,
    output logic       o_MotorDown,
    output logic       o_Alarm
);

    localparam logic [TW-1:0] GATE_LD  = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] MOVE_LD  = TW'(MOVE_CYCLES - 1);
    localparam logic [TW-1:0] UP_LD    = TW'(MAX_UP_CYCLES - 1);
    localparam logic [TW-1:0] GREEN_LD = TW'(MIN_GREEN_CYCLES - 1);

    state_e        r_state, w_next;
    out_s          r_out;
    logic          r_alarm;
    logic          w_fault;
    logic          w_seq_load, w_seq_zero;
    logic [TW-1:0] w_seq_val;
    logic          w_mg_load, w_mg_zero;

    bridge_timer #(.TW(TW)) u_seq_timer (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_load    (w_seq_load),
        .i_load_val(w_seq_val),
        .o_zero    (w_seq_zero)
    );

    bridge_timer #(.TW(TW)) u_green_timer (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_load    (w_mg_load),
        .i_load_val(GREEN_LD),
        .o_zero    (w_mg_zero)
    );

    always_comb begin
        w_fault = ((r_state == RAISING) || (r_state == BRIDGE_UP)) && i_ExistCar;
        w_next  = r_state;
        case (r_state)
            ROAD_OPEN:  if (i_BoatReq && w_mg_zero) w_next = ROAD_WARN;
            ROAD_WARN:  if (w_seq_zero)             w_next = ROAD_DRAIN;
            ROAD_DRAIN: if (!i_ExistCar)            w_next = RAISING;
            RAISING: begin
                if (w_fault)         w_next = LOWERING;
                else if (w_seq_zero) w_next = BRIDGE_UP;
            end
            BRIDGE_UP:  if (w_fault || i_BoatClear || w_seq_zero) w_next = LOWERING;
            LOWERING:   if (w_seq_zero)             w_next = ROAD_OPEN;
            default:    w_next = ROAD_OPEN;
        endcase
    end

    // Every transition enters a different state, so a state change is the load strobe.
    always_comb begin
        w_seq_load = (w_next != r_state);
        w_seq_val  = '0;
        case (w_next)
            ROAD_WARN:          w_seq_val = GATE_LD;
            RAISING, LOWERING:  w_seq_val = MOVE_LD;
            BRIDGE_UP:          w_seq_val = UP_LD;
            default:            w_seq_val = '0;
        endcase
        w_mg_load = (r_state == LOWERING) && (w_next == ROAD_OPEN);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ROAD_OPEN;
            r_out   <= '0;
            r_alarm <= 1'b0;
        end else begin
            r_state <= w_next;
            r_out   <= decode_outputs(w_next);
            r_alarm <= r_alarm | w_fault;
        end
    end

    assign o_CarLight  = r_out.car_light;
    assign o_BoatLight = r_out.boat_light;
    assign o_GateDown  = r_out.gate_down;
    assign o_MotorUp   = r_out.motor_up;
    assign o_MotorDown = r_out.motor_down;
    assign o_Alarm     = r_alarm;

endmodule

// File: tb/tb_bridge_controller.sv
// Bench for bridge_controller: each boat cycle is predicted as a timeline of
// phase lengths and compared cycle by cycle against the DUT outputs.
module tb_bridge_controller;

    localparam int G     = 8;
    localparam int M     = 16;
    localparam int MAXUP = 64;
    localparam int MG    = 32;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       ExistCar = 1'b0;
    logic       BoatReq = 1'b0;
    logic       BoatClear = 1'b0;
    logic [1:0] CarLight;
    logic       BoatLight, GateDown, MotorUp, MotorDown, Alarm;

    int n_tests = 0;
    int n_fail  = 0;

    // Sample layout: {light[1:0], boat, gate, up, down, alarm}
    logic [6:0] obs_q[$];
    logic [6:0] exp_q[$];

    always #5 Clk = ~Clk;

    bridge_controller #(
        .GATE_CYCLES(G), .MOVE_CYCLES(M), .MAX_UP_CYCLES(MAXUP),
        .MIN_GREEN_CYCLES(MG), .TW(8)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_ExistCar (ExistCar),
        .i_BoatReq  (BoatReq),
        .i_BoatClear(BoatClear),
        .o_CarLight (CarLight),
        .o_BoatLight(BoatLight),
        .o_GateDown (GateDown),
        .o_MotorUp  (MotorUp),
        .o_MotorDown(MotorDown),
        .o_Alarm    (Alarm)
    );

    // Phase: 0 open, 1 warn, 2 drain, 3 raise, 4 up, 5 lower
    function automatic logic [5:0] phase_out(input int ph);
        case (ph)
            1:       return {2'b01, 4'b0000};
            2:       return {2'b10, 4'b0100};
            3:       return {2'b10, 4'b0110};
            4:       return {2'b10, 4'b1100};
            5:       return {2'b10, 4'b0101};
            default: return {2'b00, 4'b0000};
        endcase
    endfunction

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0; BoatReq = 1'b0; ExistCar = 1'b0; BoatClear = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
    endtask

    // drainD: cycles ExistCar held in drain; clearD: BoatClear delay into up (-1 none);
    // f: ExistCar pulse offset from raise start (-1 none); hold: BoatReq kept high.
    task automatic run_boat_cycle(input int drainD, input int clearD, input int f,
                                  input bit hold, input int dropT);
        int R0, U0n, L0, O0, raiseLen, upLen, alarmT, endT, ph;
        R0 = G + 2 + drainD;
        U0n = R0 + M;
        alarmT = -1;
        if (f >= 0 && f < M) begin
            raiseLen = f + 1; upLen = 0; alarmT = R0 + f + 1;
        end else begin
            raiseLen = M; upLen = MAXUP;
            if (clearD >= 0 && clearD + 1 <= upLen) upLen = clearD + 1;
            if (f >= 0 && f - M + 1 <= upLen) begin
                upLen = f - M + 1; alarmT = R0 + f + 1;
            end
        end
        L0 = R0 + raiseLen + upLen;
        O0 = L0 + M;
        endT = O0 + MG + 3;
        obs_q.delete(); exp_q.delete();
        do_reset();
        for (int t = 0; t <= endT; t++) begin
            if (t > 0) @(negedge Clk);
            if (t < 1)                  ph = 0;
            else if (t <= G)            ph = 1;
            else if (t < R0)            ph = 2;
            else if (t < R0 + raiseLen) ph = 3;
            else if (t < L0)            ph = 4;
            else if (t < O0)            ph = 5;
            else if (t < O0 + MG)       ph = 0;
            else                        ph = hold ? 1 : 0;
            exp_q.push_back({phase_out(ph), (alarmT >= 0 && t >= alarmT)});
            obs_q.push_back({CarLight, BoatLight, GateDown, MotorUp, MotorDown, Alarm});
            BoatReq   = hold ? 1'b1 : (t < dropT);
            ExistCar  = (t >= G + 1 && t <= G + drainD) || (f >= 0 && t == R0 + f);
            BoatClear = (clearD >= 0 && t == U0n + clearD) || t == 2 || t == O0 + 3;
        end
        BoatReq = 1'b0; ExistCar = 1'b0; BoatClear = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({CarLight, BoatLight, GateDown, MotorUp, MotorDown, Alarm} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_async got=%b exp=%b",
                     {CarLight, BoatLight, GateDown, MotorUp, MotorDown, Alarm}, 7'b0);
        end
        repeat (3) @(negedge Clk);
        n_tests++;
        if ({CarLight, BoatLight, GateDown, MotorUp, MotorDown, Alarm} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_held got=%b exp=%b",
                     {CarLight, BoatLight, GateDown, MotorUp, MotorDown, Alarm}, 7'b0);
        end
    endtask

    task automatic test_basic();
        run_boat_cycle(0, 0, -1, 1'b0, 3);
        for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i] || (obs_q[3] && obs_q[2] && obs_q[1] === 1'b1)) begin
                n_fail++;
                $display("FAIL basic t=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_drain_wait();
        run_boat_cycle(20, 5, -1, 1'b0, G);
        for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL drain_wait t=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_timeout();
        run_boat_cycle(2, -1, -1, 1'b0, 1);
        for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL up_timeout t=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_clear_at_expiry();
        run_boat_cycle(0, MAXUP - 1, -1, 1'b0, 4);
        for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL clear_at_expiry t=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_fault();
        int cfg[3][2] = '{'{M + 10, 30}, '{M + 7, 7}, '{3, 2}};
        for (int k = 0; k < 3; k++) begin
            run_boat_cycle(1, cfg[k][1], cfg[k][0], 1'b0, 2);
            for (int i = 0; i < obs_q.size(); i++) begin
                n_tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL fault%0d t=%0d got=%b exp=%b", k, i, obs_q[i], exp_q[i]);
                end
            end
        end
        do_reset();
        n_tests++;
        if (Alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL alarm_cleared got=%b exp=0", Alarm);
        end
    endtask

    task automatic test_min_green();
        run_boat_cycle(0, 3, -1, 1'b1, 0);
        for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL min_green t=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int d, c, f, dt;
        bit h;
        for (int k = 0; k < 8; k++) begin
            d  = int'($urandom_range(0, 25));
            c  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 70));
            f  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, M + 70));
            h  = 1'($urandom_range(0, 1));
            dt = int'($urandom_range(1, G));
            run_boat_cycle(d, c, f, h, dt);
            for (int i = 0; i < obs_q.size(); i++) begin
                n_tests++;
                if (obs_q[i] !== exp_q[i] ||
                    (obs_q[i][2] && obs_q[i][1]) ||
                    ((obs_q[i][2] || obs_q[i][1]) && !obs_q[i][3])) begin
                    n_fail++;
                    $display("FAIL random%0d(d=%0d c=%0d f=%0d h=%0d) t=%0d got=%b exp=%b",
                             k, d, c, f, h, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        BoatReq = 1'b1;
        repeat (G + 2 + 4) @(negedge Clk);
        @(posedge Clk);
        #2;
        n_tests++;
        if (MotorUp !== 1'b1 || MotorDown !== 1'b0 || GateDown !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_raise got up=%b down=%b gate=%b exp up=1 down=0 gate=1",
                     MotorUp, MotorDown, GateDown);
        end
        Reset = 1'b0;
        #1;
        n_tests++;
        if ({CarLight, BoatLight, GateDown, MotorUp, MotorDown, Alarm} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_mid_raise got=%b exp=%b",
                     {CarLight, BoatLight, GateDown, MotorUp, MotorDown, Alarm}, 7'b0);
        end
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        n_tests++;
        if ({CarLight, BoatLight, GateDown, MotorUp, MotorDown, Alarm} !== 7'b0100000) begin
            n_fail++;
            $display("FAIL served_after_reset got=%b exp=%b",
                     {CarLight, BoatLight, GateDown, MotorUp, MotorDown, Alarm}, 7'b0100000);
        end
        BoatReq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drain_wait();
        test_timeout();
        test_clear_at_expiry();
        test_fault();
        test_min_green();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bridge_controller.md
# bridge_controller

Drawbridge sequencing controller, directly downstream of the car counter: consumes its `ExistCar` occupancy flag, plus boat request/clear signals from the river side. It runs the road traffic light, barrier gate and bridge motor through a fixed safe sequence: warn, block, drain, raise, hold, lower, reopen. The bridge is never raised while `ExistCar` is high.

## Interface
- `GATE_CYCLES`, 8: dwell in yellow-light warn state before the gate drops.
- `MOVE_CYCLES`, 16: motor run time for a full raise or lower.
- `MAX_UP_CYCLES`, 64: maximum time in the up state without `BoatClear`.
- `MIN_GREEN_CYCLES`, 32: minimum road-open time after reopening before a new boat request is served.
- `TW`, 8: timer width; every cycle parameter must be ≥1 and ≤2^TW.

Ports:
- `Clk` in 1: clock, rising edge.
- `Reset` in 1: asynchronous, active-low.
- `ExistCar` in 1: high while the car counter holds a nonzero count.
- `BoatReq` in 1: level; a boat is waiting to pass.
- `BoatClear` in 1: one-cycle pulse; the boat has passed.
- `CarLight` out 2: 2'b00 green, 2'b01 yellow, 2'b10 red.
- `BoatLight` out 1: 1 means boat may pass.
- `GateDown` out 1: road barrier lowered.
- `MotorUp` out 1: drive bridge up.
- `MotorDown` out 1: drive bridge down.
- `Alarm` out 1: sticky occupancy fault.

## Operation
States:
- **ROAD_OPEN**
  - Light is green; gate, motors and boat light are 0.
  - Moves to ROAD_WARN when `BoatReq`=1 and the min-green timer has expired.
- **ROAD_WARN**
  - Light is yellow.
  - Dwells `GATE_CYCLES` cycles, then moves to ROAD_DRAIN.
  - Dropping `BoatReq` here does not abort the sequence; it is committed.
- **ROAD_DRAIN**
  - Light is red; `GateDown`=1.
  - Waits until `ExistCar`=0, then moves to RAISING. There is no timeout.
- **RAISING**
  - Light red, `GateDown`=1, `MotorUp`=1.
  - Dwells `MOVE_CYCLES` cycles, then moves to BRIDGE_UP.
- **BRIDGE_UP**
  - Light red, `GateDown`=1, `BoatLight`=1.
  - Moves to LOWERING on `BoatClear`, or when `MAX_UP_CYCLES` expires, whichever comes first.
- **LOWERING**
  - Light red, `GateDown`=1, `MotorDown`=1.
  - Dwells `MOVE_CYCLES` cycles, then moves to ROAD_OPEN and reloads the min-green timer.

Rules:
- **Occupancy fault:** `ExistCar`=1 sampled in RAISING or BRIDGE_UP sets `Alarm`, and the state moves to LOWERING next cycle. `Alarm` clears only on `Reset`.
- **Ignored pulses:** `BoatClear` outside BRIDGE_UP is ignored.
- **Simultaneous events:**
  - `BoatClear` with timer expiry: LOWERING, one transition only.
  - Fault with `BoatClear`: LOWERING plus `Alarm`.
- **Motor interlock:** `MotorUp` and `MotorDown` are never both 1, and neither is 1 unless `GateDown`=1.
- **Min-green at reset:** the timer starts expired, so a request already pending out of reset is served at once.
- **Timer:** one shared down-counter of width `TW`.
  - On each state entry it is loaded with N-1; it decrements each cycle.
  - The exit condition is timer==0, giving an exact dwell of N cycles.
  - The counter never wraps: it holds at 0.

## Timing
- **Registered outputs:** all outputs are registered and decoded from the registered state. An output changes in the cycle the new state is entered.
- **Input latency:** an input sampled on edge k causes the state change at edge k+1. Inputs are assumed synchronous to `Clk`.
- **`ExistCar` lag:** it lags the counter's `CarOut` by one cycle, so drain exit is at least 2 cycles after the last car leaves.
- **Reset values:** `Reset`=0 asynchronously forces, from any state including mid-raise:
  - state ROAD_OPEN, timer 0;
  - `CarLight`=2'b00;
  - `BoatLight`, `GateDown`, `MotorUp`, `MotorDown`, `Alarm` all 0.
- **Reset scope:** system-level reset is only issued with the bridge physically down.
- **Minimum cycle time:** a full boat cycle with an immediate `BoatClear` takes `GATE_CYCLES` + drain + 2×`MOVE_CYCLES` + 1 cycles.

## Structure
- **Shared package:** the `bridge_pkg` include holds the state encodings (one-hot or binary, 3 bits) and the `CarLight` codes (GREEN, YELLOW, RED). The car counter and the top level use the same codes.
- **Sub-module:** `bridge_timer` is a loadable, saturating down-counter.
  - Ports: `Clk`, `Reset`, load, load value, zero flag.
  - It is instantiated twice: one sequence timer and one min-green timer.
- **Top module:** FSM next-state logic, registered output decode, and the sticky `Alarm` register.

## Test plan
- **Basic cycle:** reset, `BoatReq`=1 with `ExistCar`=0 (defaults) → yellow for 8 cycles, red+gate, `MotorUp` for 16, `BoatLight`=1; `BoatClear` pulse → `MotorDown` for 16, then green.
- **Drain wait:** `ExistCar`=1 held 20 cycles during ROAD_DRAIN → no `MotorUp` until 1 cycle after `ExistCar` falls.
- **Up-state timeout:** no `BoatClear` → LOWERING after exactly 64 cycles in BRIDGE_UP.
- **Occupancy fault:** `ExistCar` pulsed in BRIDGE_UP → `Alarm`=1 and LOWERING next cycle; `Alarm` still 1 back in ROAD_OPEN until `Reset`.
- **Min-green hold-off:** `BoatReq` held across reopen → ROAD_WARN entered exactly 32 cycles after ROAD_OPEN.
- **Reset mid-operation:** `Reset` asserted mid-RAISING → all outputs at reset values immediately, asynchronously; the interlock assertion holds throughout.
